// File: rtl/fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_issue_ctrl
//   Issue/response controller between a core and an RV32F floating-point unit.
//   It accepts one FP instruction at a time, decodes OP-FP / FLW / FSW, and
//   resolves the rounding mode. It then launches the FPU and waits a fixed
//   latency before presenting a response. It also owns the fcsr register,
//   which holds {frm, fflags}.
//
//   Configuration macro: FPU_DYN_RM_EN
//     defined   : rm=111 selects the dynamic rounding mode held in fcsr.frm
//     undefined : rm=111 is illegal, frm is constant 000, csr_wdata[7:5] unused
//
//   Parameter
//     FPU_LATENCY  cycles from fpu_start to f_flags valid for OP-FP (1..15)
//
//   Ports
//     clk, rst                       clock, synchronous active-high reset
//     issue_valid/issue_ready/instr  instruction handshake from the core
//     f_rs1/f_rs2/f_rd/f_funct_7     latched register fields to the FPU
//     f_frm_in, f_LW, f_SW           latched rounding mode and load/store decode
//     fpu_start                      one-cycle launch pulse
//     f_flags                        exception flags returned by the FPU
//     resp_valid/resp_ready/illegal  response handshake; illegal qualifies it
//     csr_we/csr_wdata/fcsr_out      fcsr write port and read-out
// -----------------------------------------------------------------------------
module fpu_issue_ctrl #(
  parameter int unsigned FPU_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [31:0] instr,
  output logic [4:0]  f_rs1,
  output logic [4:0]  f_rs2,
  output logic [4:0]  f_rd,
  output logic [7:0]  f_funct_7,
  output logic [2:0]  f_frm_in,
  output logic        f_LW,
  output logic        f_SW,
  output logic        fpu_start,
  input  logic [4:0]  f_flags,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        illegal,
  input  logic        csr_we,
  input  logic [7:0]  csr_wdata,
  output logic [7:0]  fcsr_out
);

  localparam logic [3:0] LAT_C       = 4'(FPU_LATENCY);
  localparam logic [6:0] OPC_OP_FP   = 7'b1010011;
  localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic [3:0]  count_r;
  logic        op_fp_r;
  logic [2:0]  frm_r;
  logic [4:0]  fflags_r;

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic        is_opfp_s;
  logic        is_flw_s;
  logic        is_fsw_s;
  logic [2:0]  rm_res_s;
  logic        rm_ok_s;
  logic        legal_s;
  logic [2:0]  frm_dec_s;
  logic        accept_s;
  logic        accum_s;

  assign issue_ready = (state_r == IDLE);
  assign resp_valid  = (state_r == RESP);
  assign fcsr_out    = {frm_r, fflags_r};
  assign accept_s    = issue_valid && (state_r == IDLE);
  // Flags are folded in on the last EXEC cycle, the same edge that enters RESP.
  assign accum_s     = (state_r == EXEC) && (count_r == 4'd1) && op_fp_r;

  // Instruction decode and rounding-mode resolution.
  always_comb begin
    opcode_s  = instr[6:0];
    funct3_s  = instr[14:12];
    is_opfp_s = (opcode_s == OPC_OP_FP);
    is_flw_s  = (opcode_s == OPC_LOAD_FP) && (funct3_s == 3'b010);
    is_fsw_s  = (opcode_s == OPC_STORE_FP) && (funct3_s == 3'b010);
`ifdef FPU_DYN_RM_EN
    if (funct3_s == 3'b111) begin
      rm_res_s = frm_r;
    end else begin
      rm_res_s = funct3_s;
    end
`else
    rm_res_s = funct3_s;
`endif
    // 101/110/111 after resolution are reserved encodings.
    rm_ok_s = (rm_res_s <= 3'b100);
    legal_s = is_flw_s || is_fsw_s || (is_opfp_s && rm_ok_s);
    if (is_opfp_s && rm_ok_s) begin
      frm_dec_s = rm_res_s;
    end else begin
      frm_dec_s = 3'b000;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (legal_s) begin
            state_nx_s = EXEC;
          end else begin
            state_nx_s = RESP;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      EXEC: begin
        if (count_r == 4'd1) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = EXEC;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register, latency counter and launch pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      count_r   <= 4'd0;
      fpu_start <= 1'b0;
      op_fp_r   <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      fpu_start <= accept_s && legal_s;
      if (accept_s) begin
        op_fp_r <= is_opfp_s && rm_ok_s;
        if (legal_s) begin
          count_r <= is_opfp_s ? LAT_C : 4'd1;
        end
      end else if ((state_r == EXEC) && (count_r != 4'd0)) begin
        count_r <= count_r - 4'd1;
      end
    end
  end

  // Decoded fields are captured at accept and held for the whole operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_rs1     <= 5'd0;
      f_rs2     <= 5'd0;
      f_rd      <= 5'd0;
      f_funct_7 <= 8'd0;
      f_frm_in  <= 3'd0;
      f_LW      <= 1'b0;
      f_SW      <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept_s) begin
      f_rs1     <= instr[19:15];
      f_rs2     <= instr[24:20];
      f_rd      <= instr[11:7];
      f_funct_7 <= {1'b0, instr[31:25]};
      f_frm_in  <= frm_dec_s;
      f_LW      <= is_flw_s;
      f_SW      <= is_fsw_s;
      illegal   <= !legal_s;
    end
  end

  // Sticky exception flags; a CSR write in the accumulating cycle merges both.
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags_r <= 5'd0;
    end else if (csr_we) begin
      fflags_r <= csr_wdata[4:0] | (accum_s ? f_flags : 5'd0);
    end else if (accum_s) begin
      fflags_r <= fflags_r | f_flags;
    end
  end

`ifdef FPU_DYN_RM_EN
  // Dynamic rounding mode register; the in-flight op keeps its latched copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_r <= 3'd0;
    end else if (csr_we) begin
      frm_r <= csr_wdata[7:5];
    end
  end
`else
  logic unused_frm_s;
  assign frm_r        = 3'b000;
  assign unused_frm_s = ^csr_wdata[7:5];
`endif

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter FPU_LATENCY, default 3, meaning cycles from fpu_start to f_flags valid for OP-FP ops (legal range 1..15).
REQ-002 SHALL have port clk  input  1  clock; one clock domain, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port issue_valid  input  1  core presents FP instruction.
REQ-005 SHALL have port issue_ready  output  1  block accepts instruction.
REQ-006 SHALL have port instr  input  32  raw RV32F instruction word.
REQ-007 SHALL have ports f_rs1, f_rs2, f_rd  output  5 each  register fields to FPU.
REQ-008 SHALL have port f_funct_7  output  8  {1'b0, instr[31:25]}.
REQ-009 SHALL have port f_frm_in  output  3  resolved rounding mode.
REQ-010 SHALL have ports f_LW, f_SW  output  1 each  FLW / FSW decode.
REQ-011 SHALL have port fpu_start  output  1  one-cycle launch pulse.
REQ-012 SHALL have port f_flags  input  5  NV,DZ,OF,UF,NX from FPU.
REQ-013 SHALL have port resp_valid  output  1  operation complete.
REQ-014 SHALL have port resp_ready  input  1  core consumes response.
REQ-015 SHALL have port illegal  output  1  qualifies resp_valid; instruction rejected.
REQ-016 SHALL have ports csr_we  input  1, csr_wdata  input  8, fcsr_out  output  8 ({frm,fflags}).

Function
REQ-017 SHALL implement states IDLE, EXEC, RESP; issue_ready=1 only in IDLE.
REQ-018 SHALL accept on issue_valid && issue_ready; register all decoded outputs, hold them stable until return to IDLE.
REQ-019 SHALL decode opcode 1010011 (OP-FP), 0000111 with funct3=010 (FLW), 0100111 with funct3=010 (FSW); anything else is illegal.
REQ-020 SHALL, for OP-FP, take rm=instr[14:12]; rm=111 resolves to fcsr frm; resolved 101/110/111 is illegal.
REQ-021 SHALL, for FLW/FSW, drive f_frm_in=000 and skip rounding checks.
REQ-022 SHALL on legal accept go IDLE->EXEC, pulse fpu_start in the first EXEC cycle, load counter with FPU_LATENCY (OP-FP) or 1 (FLW/FSW).
REQ-023 SHALL decrement counter each EXEC cycle; at count 1 go EXEC->RESP and OR f_flags into fflags (OP-FP only).
REQ-024 SHALL on illegal accept go IDLE->RESP directly with illegal=1, no fpu_start, no flag update.
REQ-025 SHALL hold resp_valid=1 in RESP until resp_ready=1, then return to IDLE; next accept earliest the following cycle.
REQ-026 SHALL keep fflags sticky; only csr_we or rst clears bits.
REQ-027 SHALL, when csr_we coincides with flag accumulation, store csr_wdata[4:0] | f_flags.
REQ-028 SHALL accept csr_we in any state; frm change during EXEC does not alter the latched f_frm_in.
REQ-029 SHALL drive fcsr_out combinationally from the fcsr register.

Reset
REQ-030 SHALL on rst go to IDLE, clear counter, fcsr=0, and drive all outputs 0 except issue_ready=1.
REQ-031 SHALL on rst during EXEC or RESP abandon the operation: no response, no flag update.

Configuration
REQ-032 SHALL support macro FPU_DYN_RM_EN. When defined, rm=111 resolves per REQ-020. When undefined, rm=111 is illegal, frm is constant 000, and csr_wdata[7:5] is ignored.

Verification
REQ-033 SHALL check FADD.S (instr=0x003100D3, rm=000): fpu_start 1 cycle after accept, resp_valid exactly FPU_LATENCY cycles after fpu_start, f_rd=1, f_rs1=2, f_rs2=3.
REQ-034 SHALL check f_flags=00001 then 10000 on two ops: fcsr_out[4:0]=10001; csr_we with 0x00 clears it.
REQ-035 SHALL check rm=101 and opcode 0x33: resp_valid with illegal=1 the cycle after accept, no fpu_start.
REQ-036 SHALL check dynamic rm (frm=010 via csr_we, rm=111): f_frm_in=010 with FPU_DYN_RM_EN; illegal=1 without.
REQ-037 SHALL check resp_ready held low 5 cycles: resp_valid and outputs stable, issue_ready=0 throughout.
REQ-038 SHALL check rst asserted in EXEC: next cycle IDLE, fcsr_out=0, no resp_valid.
